mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter that shares one unified memory port between the instruction cache and the data cache of the pipelined MIPS core. It sits between the two caches' memory-side interfaces and the RAM, sequences one transaction at a time with a registered grant FSM, and gives the data cache priority with a bounded-starvation guarantee for instruction fetch.

## Interface
- Parameter `DSTREAK_MAX`, default 4: the maximum number of consecutive dcache grants while an ifetch is pending. Legal range is 1..15.
- `CLK`, in, 1: clock.
- `nRST`, in, 1: reset, asynchronous, active-low.
- `iREN`, in, 1: icache read request.
- `iaddr`, in, 32: icache word address.
- `iwait`, out, 1: low for exactly the cycle the icache read completes.
- `iload`, out, 32: instruction read data.
- `dREN`, in, 1: dcache read request.
- `dWEN`, in, 1: dcache write request.
- `daddr`, in, 32: dcache address.
- `dstore`, in, 32: dcache write data.
- `dwait`, out, 1: low for exactly the cycle the dcache access completes.
- `dload`, out, 32: data read data.
- `ramREN`, out, 1: RAM read enable.
- `ramWEN`, out, 1: RAM write enable.
- `ramaddr`, out, 32: RAM address.
- `ramstore`, out, 32: RAM write data.
- `ramload`, in, 32: RAM read data.
- `ramstate`, in, 2: RAM status, `ramstate_t`. Encodings are FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `ram_err`, out, 1: one-cycle pulse when the granted access sees ERROR.

## Operation
- The FSM has three states: IDLE, GNT_I and GNT_D. It also holds a 4-bit `dstreak` counter.
- **Arbitration in IDLE**, evaluated each cycle:
  - If a dcache request (`dREN|dWEN`) is present and not (`iREN` and `dstreak==DSTREAK_MAX`), go to GNT_D.
  - Otherwise, if `iREN` is present, go to GNT_I.
  - Otherwise, stay in IDLE.
- **GNT_D:**
  - `ramaddr=daddr` and `ramstore=dstore`.
  - If `dWEN` is high, drive `ramWEN=1` and `ramREN=0`. `dWEN` wins if both `dREN` and `dWEN` are high.
  - Otherwise drive `ramREN=dREN`.
- **GNT_I:** `ramREN=1` and `ramaddr=iaddr`.
- **RAM signals:** all RAM outputs are 0 in IDLE. They are driven combinationally from the granted requester's live inputs, so an address change mid-grant retargets the access.
- **Completion:** in a grant state with `ramstate==ACCESS`:
  - The granted requester's wait signal goes low that same cycle.
  - The load output equals `ramload` that same cycle.
  - The FSM goes to IDLE on the next edge.
- **BUSY or FREE during a grant:** hold the grant with wait high.
- **ERROR during a grant:**
  - Pulse `ram_err` and keep wait high.
  - Remain in the grant state, so the access retries until ACCESS.
- **Abort:** if the granted requester drops all of its enables before ACCESS, the RAM enables drop that same cycle. The FSM returns to IDLE, with no wait-low pulse and no `dstreak` change.
- **`dstreak` update:**
  - +1 on each completed GNT_D access if `iREN` was high at that completion, saturating at `DSTREAK_MAX`.
  - Cleared on each completed GNT_I access.
  - Cleared in IDLE when `iREN` is low.
- **Non-granted outputs:** the non-granted requester always sees wait=1 and load=0.

## Timing
- **Reset values:**
  - FSM is IDLE and `dstreak` is 0.
  - `iwait=dwait=1` and `iload=dload=0`.
  - `ramREN=ramWEN=0`, `ramaddr=ramstore=0` and `ram_err=0`.
- **Latency:**
  - Request sampled in IDLE at edge t; grant state is active from cycle t+1.
  - The minimum access has ACCESS in cycle t+1, giving wait low in t+1.
  - The FSM is back in IDLE at t+2, so there is a turnaround of 1 dead cycle between back-to-back transactions.
- **Simultaneous requests in IDLE:** the dcache wins unless the streak limit has been reached.
- **Same-cycle inputs:** a request arriving in the same cycle ACCESS completes another transaction is arbitrated in the following IDLE cycle.
- **Reset mid-transaction:** the FSM returns to IDLE asynchronously and the RAM enables drop immediately. The in-flight access is discarded and no wait-low pulse is emitted.
- **Requester obligations:** requesters hold address, data and enables stable until their wait goes low or they deliberately abort.

## Structure
- `ramstate_t` and `word_t` belong in `cpu_types_pkg`.
- Add `arb_state_t` (IDLE, GNT_I, GNT_D) to `cpu_types_pkg`.
- Single module: one `always_ff` for state and `dstreak`, and one `always_comb` for next-state and outputs.
- No sub-module.

## Test plan
- **Reset:** assert `nRST=0` mid-GNT_D with `ramstate=BUSY` → all outputs at their reset values in the same cycle, and FSM IDLE after release.
- **Lone ifetch:** `iREN=1`, `iaddr=0x0000_0040`, RAM returns ACCESS after 2 BUSY cycles with `ramload=0x2408_0001` → `ramREN=1` and `ramaddr=0x40` from cycle 1, `iwait` low in cycle 3 with `iload=0x2408_0001`, and FSM IDLE in cycle 4.
- **Conflict:** `iREN` and `dWEN` asserted together with `daddr=0x100` and `dstore=0xDEAD_BEEF` → GNT_D first with `ramWEN=1` and `ramstore=0xDEADBEEF`, then GNT_I after 1 idle cycle.
- **Starvation bound:**
  - Stimulus: `iREN` held high, dcache issues continuous reads, `DSTREAK_MAX=4`.
  - Required: exactly 4 dcache completions, then an icache grant, then `dstreak` is 0 and the dcache is granted again.
- **Error retry:** in GNT_I, `ramstate` sequence ERROR, ERROR, ACCESS → `ram_err` pulses in two cycles, `iwait` stays high until the ACCESS cycle, and there is exactly one completion.
- **Abort:** during GNT_D with `ramstate=BUSY`, drop `dREN` → `ramREN` goes to 0 the same cycle, the FSM goes to IDLE next, `dwait` never goes low, and `dstreak` is unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word, RAM status and memory arbiter state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache; dcache has priority, ifetch starvation bounded by DSTREAK_MAX.
// Latency: request sampled in IDLE, granted next cycle, wait drops in the ACCESS cycle; 1 dead cycle between grants.
// Backpressure: requesters hold inputs while their wait is high; RAM stalls with BUSY/FREE, ERROR retries the access.
//
// Ports:
//   CLK, nRST                        clock, async active-low reset
//   iREN, iaddr -> iwait, iload      icache read side
//   dREN, dWEN, daddr, dstore
//                -> dwait, dload     dcache read/write side
//   ramREN, ramWEN, ramaddr,
//   ramstore <- ramload, ramstate    unified RAM port
//   ram_err                          pulses each cycle the granted access sees ERROR
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ram_err
);

    localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

    arb_state_t state, state_next;
    logic [3:0] dstreak, dstreak_next;
    logic       d_req;

    assign d_req = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            dstreak <= '0;
        end else begin
            state   <= state_next;
            dstreak <= dstreak_next;
        end
    end

    always_comb begin
        state_next   = state;
        dstreak_next = dstreak;
        iwait        = 1'b1;
        iload        = '0;
        dwait        = 1'b1;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        ram_err      = 1'b0;

        case (state)
            IDLE: begin
                // A streak only matters while an ifetch is actually waiting.
                if (!iREN) begin
                    dstreak_next = '0;
                end
                if (d_req && !(iREN && (dstreak == STREAK_MAX))) begin
                    state_next = GNT_D;
                end else if (iREN) begin
                    state_next = GNT_I;
                end
            end

            GNT_I: begin
                if (!iREN) begin
                    // Abort: enables fall now, no completion, streak untouched.
                    state_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    case (ramstate)
                        ACCESS: begin
                            iwait        = 1'b0;
                            iload        = ramload;
                            state_next   = IDLE;
                            dstreak_next = '0;
                        end
                        ERROR:   ram_err = 1'b1;
                        default: ;
                    endcase
                end
            end

            GNT_D: begin
                if (!d_req) begin
                    state_next = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    // Write wins when both enables are raised.
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    case (ramstate)
                        ACCESS: begin
                            dwait      = 1'b0;
                            dload      = ramload;
                            state_next = IDLE;
                            if (iREN && (dstreak != STREAK_MAX)) begin
                                dstreak_next = dstreak + 4'd1;
                            end
                        end
                        ERROR:   ram_err = 1'b1;
                        default: ;
                    endcase
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized icache/dcache traffic against a RAM model,
// with expected responses queued at issue time and popped by a monitor on each wait-low cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int DMAX = 4;

    logic      CLK, nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN, ram_err;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    ramstate_t dir_st, auto_st;
    word_t     dir_load, auto_load;
    bit        ram_auto = 0;
    bit        mon_en   = 0;

    assign ramstate = ram_auto ? auto_st   : dir_st;
    assign ramload  = ram_auto ? auto_load : dir_load;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic  wr;
        word_t addr;
        word_t data;
    } exp_t;

    exp_t  iq[$];
    exp_t  dq[$];
    word_t mem[word_t];   // RAM contents as the RAM model sees them
    word_t dref[word_t];  // dcache's view, updated when a write is issued

    mem_arbiter #(.DSTREAK_MAX(DMAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic word_t init_val(word_t a);
        return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0003};
    endfunction

    function automatic word_t rd_mem(word_t a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    task automatic chk(string nm, word_t act, word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not expected / not seen at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(string tag);
        chk1({tag, "_iwait"},   iwait,    1'b1);
        chk1({tag, "_dwait"},   dwait,    1'b1);
        chk ({tag, "_iload"},   iload,    '0);
        chk ({tag, "_dload"},   dload,    '0);
        chk1({tag, "_ramREN"},  ramREN,   1'b0);
        chk1({tag, "_ramWEN"},  ramWEN,   1'b0);
        chk ({tag, "_ramaddr"}, ramaddr,  '0);
        chk ({tag, "_ramstore"},ramstore, '0);
        chk1({tag, "_ram_err"}, ram_err,  1'b0);
    endtask

    // RAM model for the random phase: random status per granted cycle, data from mem[].
    initial begin
        int r;
        auto_st   = FREE;
        auto_load = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (ram_auto && (ramREN || ramWEN)) begin
                r = $urandom_range(0, 9);
                if (r < 5)      auto_st = ACCESS;
                else if (r < 8) auto_st = BUSY;
                else if (r < 9) auto_st = FREE;
                else            auto_st = ERROR;
                auto_load = rd_mem(ramaddr);
            end else begin
                auto_st   = FREE;
                auto_load = '0;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (ram_auto && ramWEN && ramstate == ACCESS) mem[ramaddr] = ramstore;
    end

    // Monitor: pops the oldest expectation of whichever side completes.
    initial begin
        exp_t e;
        int   run;
        run = 0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (!iREN) run = 0;
                if (!iwait) begin
                    run = 0;
                    if (iq.size() == 0) fail("i_spurious_done");
                    else begin
                        e = iq.pop_front();
                        chk ("i_addr", ramaddr, e.addr);
                        chk1("i_ren",  ramREN,  1'b1);
                        chk ("i_load", iload,   e.data);
                        chk1("i_other_dwait", dwait, 1'b1);
                        chk ("i_other_dload", dload, '0);
                    end
                end
                if (!dwait) begin
                    if (dq.size() == 0) fail("d_spurious_done");
                    else begin
                        e = dq.pop_front();
                        chk ("d_addr", ramaddr, e.addr);
                        chk1("d_wen",  ramWEN,  e.wr);
                        chk1("d_ren",  ramREN,  ~e.wr);
                        if (e.wr) chk("d_store", ramstore, e.data);
                        else      chk("d_load",  dload,    e.data);
                        chk("d_other_iload", iload, '0);
                    end
                    if (iREN) begin
                        run++;
                        n_vec++;
                        if (run > DMAX) begin
                            n_err++;
                            $display("FAIL starve_bound: %0d dcache grants in a row, limit %0d", run, DMAX);
                        end
                    end
                end
            end
        end
    end

    task automatic icache_run(int n);
        word_t a;
        int    gap, t;
        for (int k = 0; k < n; k++) begin
            gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            if (gap > 0) begin
                iREN = 1'b0;
                repeat (gap) tick();
            end
            a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            iaddr = a;
            iREN  = 1'b1;
            iq.push_back('{1'b0, a, init_val(a)});
            t = 0;
            do begin
                @(negedge CLK);
                t++;
            end while (iwait && t < 300);
            if (iwait) fail("i_timeout");
            tick();
        end
        iREN = 1'b0;
    endtask

    task automatic dcache_run(int n);
        word_t a, d;
        int    op, gap, t;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                dREN = 1'b0;
                dWEN = 1'b0;
                repeat (gap) tick();
            end
            a  = 32'h100 + 32'(4 * $urandom_range(0, 15));
            d  = $urandom;
            op = $urandom_range(0, 2);   // 0 read, 1 write, 2 both (write wins)
            daddr  = a;
            dstore = d;
            dREN   = (op != 1);
            dWEN   = (op != 0);
            if (op != 0) begin
                dref[a] = d;
                dq.push_back('{1'b1, a, d});
            end else begin
                dq.push_back('{1'b0, a, dref.exists(a) ? dref[a] : init_val(a)});
            end
            t = 0;
            do begin
                @(negedge CLK);
                t++;
            end while (dwait && t < 300);
            if (dwait) fail("d_timeout");
            tick();
        end
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    initial begin
        ramstate_t sq[5];
        logic      ew[5];
        logic      ee[5];
        int        seq[$];
        int        errs, dones;

        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        dir_st = FREE; dir_load = '0;

        @(negedge CLK);
        chk_reset_vals("rst");
        tick();
        nRST = 1'b1;

        // Lone ifetch: two BUSY cycles then ACCESS.
        tick(); iREN = 1'b1; iaddr = 32'h40; dir_st = BUSY; dir_load = 32'h2408_0001;
        @(negedge CLK); chk1("if_c0_ren", ramREN, 1'b0);
        tick(); @(negedge CLK);
        chk1("if_c1_ren", ramREN, 1'b1); chk("if_c1_addr", ramaddr, 32'h40); chk1("if_c1_iwait", iwait, 1'b1);
        tick(); @(negedge CLK); chk1("if_c2_iwait", iwait, 1'b1);
        tick(); dir_st = ACCESS; @(negedge CLK);
        chk1("if_c3_iwait", iwait, 1'b0); chk("if_c3_iload", iload, 32'h2408_0001);
        tick(); iREN = 1'b0; dir_st = FREE; @(negedge CLK);
        chk1("if_c4_ren", ramREN, 1'b0); chk1("if_c4_iwait", iwait, 1'b1);

        // Conflict: dcache write wins, icache follows after one idle cycle.
        tick(); iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        dir_st = ACCESS; dir_load = 32'h1111_2222;
        @(negedge CLK); chk1("cf_c0_wen", ramWEN, 1'b0);
        tick(); @(negedge CLK);
        chk1("cf_c1_wen", ramWEN, 1'b1); chk1("cf_c1_ren", ramREN, 1'b0);
        chk("cf_c1_addr", ramaddr, 32'h100); chk("cf_c1_store", ramstore, 32'hDEAD_BEEF);
        chk1("cf_c1_dwait", dwait, 1'b0); chk1("cf_c1_iwait", iwait, 1'b1);
        tick(); dWEN = 1'b0; @(negedge CLK);
        chk1("cf_c2_ren", ramREN, 1'b0); chk1("cf_c2_wen", ramWEN, 1'b0);
        tick(); @(negedge CLK);
        chk1("cf_c3_ren", ramREN, 1'b1); chk("cf_c3_addr", ramaddr, 32'h80);
        chk1("cf_c3_iwait", iwait, 1'b0); chk("cf_c3_iload", iload, 32'h1111_2222);
        tick(); iREN = 1'b0;

        // Starvation bound: iREN held, dcache reads back to back.
        tick(); iREN = 1'b1; iaddr = 32'hC0; dREN = 1'b1; daddr = 32'h104; dir_st = ACCESS;
        for (int c = 0; c < 40 && seq.size() < DMAX + 2; c++) begin
            @(negedge CLK);
            if (!dwait) seq.push_back(0);
            if (!iwait) seq.push_back(1);
            tick();
        end
        chk("starve_count", 32'(seq.size()), 32'(DMAX + 2));
        for (int k = 0; k < seq.size() && k < DMAX + 2; k++)
            chk($sformatf("starve_order_%0d", k), 32'(seq[k]), (k == DMAX) ? 32'd1 : 32'd0);
        iREN = 1'b0; dREN = 1'b0; dir_st = FREE;

        // Error retry in GNT_I: ERROR, ERROR, ACCESS.
        tick(); iREN = 1'b1; iaddr = 32'h44; dir_load = 32'hCAFE_0044;
        sq = '{FREE, ERROR, ERROR, ACCESS, FREE};
        ew = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ee = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        errs = 0; dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            dir_st = sq[k];
            if (k == 4) iREN = 1'b0;
            @(negedge CLK);
            chk1($sformatf("err_iwait_%0d", k), iwait, ew[k]);
            chk1($sformatf("err_pulse_%0d", k), ram_err, ee[k]);
            if (k == 3) chk("err_iload", iload, 32'hCAFE_0044);
            errs  += int'(ram_err);
            dones += int'(!iwait);
        end
        chk("err_pulses", 32'(errs), 32'd2);
        chk("err_dones",  32'(dones), 32'd1);

        // Abort during GNT_D.
        tick(); dREN = 1'b1; daddr = 32'h108; dir_st = BUSY;
        @(negedge CLK);
        tick(); @(negedge CLK); chk1("ab_c1_ren", ramREN, 1'b1);
        tick(); dREN = 1'b0; #1;
        chk1("ab_c2_ren_now", ramREN, 1'b0); chk1("ab_c2_dwait_now", dwait, 1'b1);
        @(negedge CLK); chk1("ab_c2_dwait", dwait, 1'b1);
        tick(); dREN = 1'b1; dir_st = ACCESS; @(negedge CLK);
        chk1("ab_c3_idle_ren", ramREN, 1'b0); chk1("ab_c3_idle_dwait", dwait, 1'b1);
        tick(); @(negedge CLK); chk1("ab_c4_dwait", dwait, 1'b0);
        tick(); dREN = 1'b0; dir_st = FREE;

        // Reset in the middle of a BUSY GNT_D write.
        tick(); dWEN = 1'b1; daddr = 32'h10C; dstore = 32'h0000_0123; dir_st = BUSY;
        @(negedge CLK);
        tick(); @(negedge CLK); chk1("rm_c1_wen", ramWEN, 1'b1);
        tick(); nRST = 1'b0; #1;
        chk_reset_vals("rm_mid");
        @(negedge CLK);
        tick(); nRST = 1'b1; #1;
        chk1("rm_rel_wen", ramWEN, 1'b0); chk1("rm_rel_dwait", dwait, 1'b1);
        dWEN = 1'b0; dir_st = FREE;

        // Randomized traffic.
        tick();
        ram_auto = 1'b1;
        mon_en   = 1'b1;
        fork
            icache_run(60);
            dcache_run(60);
        join
        repeat (3) tick();
        mon_en = 1'b0;
        chk("iq_left", 32'(iq.size()), 32'd0);
        chk("dq_left", 32'(dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
